core_in_desc_feeder: RTL

- Sits directly upstream of the RISC-V core wrapper's in_desc / in_desc_valid / in_desc_taken port.
- Buffers inbound packet descriptors from the scheduler in a FIFO and presents them to the core one at a time.
- Tracks which packet slots are currently handed to the core in a slot-occupancy bitmap. Slots are released from the core's out_desc path.
- Flags duplicate allocations, invalid slot IDs and spurious releases.

---
 rtl/core_desc_pkg.sv | 27 ++
 rtl/core_in_desc_feeder_if.sv | 28 ++
 rtl/core_desc_fifo.sv | 71 +++++++
 rtl/core_in_desc_feeder.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/core_desc_pkg.sv
// Shared definitions for the core inbound descriptor feeder.
// Contents:
//   - Descriptor field offsets/widths (length, slot ID, port, tag)
//   - desc_t : packed 64-bit descriptor layout
//   - SLOT_ID_W : width of the slot ID field carried in descriptors/releases
package core_desc_pkg;

    localparam int DESC_W    = 64;
    localparam int LEN_LSB   = 0;
    localparam int LEN_W     = 16;
    localparam int SLOT_LSB  = 16;
    localparam int SLOT_ID_W = 8;
    localparam int PORT_LSB  = 24;
    localparam int PORT_W    = 4;
    localparam int TAG_LSB   = 32;
    localparam int TAG_W     = 32;

    // Bits [31:28] are unused by the scheduler and carried through untouched.
    typedef struct packed {
        logic [TAG_W-1:0]     tag;   // [63:32]
        logic [3:0]           rsvd;  // [31:28]
        logic [PORT_W-1:0]    port;  // [27:24]
        logic [SLOT_ID_W-1:0] slot;  // [23:16]
        logic [LEN_W-1:0]     len;   // [15:0]
    } desc_t;

endpackage

// File: rtl/core_in_desc_feeder_if.sv
// Descriptor handshake bundle between scheduler, feeder and core.
//   s_desc / s_desc_valid / s_desc_ready : scheduler -> feeder
//   in_desc / in_desc_valid / in_desc_taken : feeder -> core
// Handshake: a beat transfers on a rising clk edge where valid && ready
// (ready is in_desc_taken on the core side). Once valid is raised the data
// holds stable until the beat transfers.
// Modports: slave = the feeder itself, master = the surrounding environment.
interface core_in_desc_feeder_if;
    import core_desc_pkg::*;

    desc_t s_desc;
    logic  s_desc_valid;
    logic  s_desc_ready;
    desc_t in_desc;
    logic  in_desc_valid;
    logic  in_desc_taken;

    modport slave (
        input  s_desc, s_desc_valid, in_desc_taken,
        output s_desc_ready, in_desc, in_desc_valid
    );

    modport master (
        output s_desc, s_desc_valid, in_desc_taken,
        input  s_desc_ready, in_desc, in_desc_valid
    );

endinterface

// File: rtl/core_desc_fifo.sv
// First-word-fall-through descriptor FIFO with a registered output stage.
// Ports:
//   clk, flush    : clock, synchronous clear of pointers/output stage
//   push, din     : write strobe (caller guarantees ready) and data
//   taken         : consumer ready; pop when valid && taken
//   dout, valid   : registered head-of-queue descriptor and its valid
//   ready         : registered !full, low during and one cycle after flush
//   count         : occupancy, wr_ptr - rd_ptr
module core_desc_fifo
    import core_desc_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic          clk,
    input  logic          flush,
    input  logic          push,
    input  desc_t         din,
    input  logic          taken,
    output desc_t         dout,
    output logic          valid,
    output logic          ready,
    output logic [PW-1:0] count
);

    desc_t         mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_next, rd_next;
    logic          pop;
    desc_t         dout_next;

    assign pop     = valid && taken;
    assign wr_next = wr_ptr + {{AW{1'b0}}, push};
    assign rd_next = rd_ptr + {{AW{1'b0}}, pop};
    assign count   = wr_ptr - rd_ptr;

    // The output register always tracks the entry rd_next will point at.
    // When that entry is the one being written this edge, take it straight
    // from din, since mem is not yet updated.
    always_comb begin
        dout_next = mem[rd_next[AW-1:0]];
        if (push && (rd_next == wr_ptr)) begin
            dout_next = din;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            dout   <= '0;
            valid  <= 1'b0;
            ready  <= 1'b0;
        end else begin
            wr_ptr <= wr_next;
            rd_ptr <= rd_next;
            dout   <= dout_next;
            valid  <= (wr_next != rd_next);
            // Full when the pointers differ only in the wrap bit.
            ready  <= ((wr_next ^ rd_next) != {1'b1, {AW{1'b0}}});
        end
    end

endmodule

// File: rtl/core_in_desc_feeder.sv
// Feeds inbound packet descriptors from the scheduler to the core, one at a
// time, while tracking which packet slots the core currently owns.
// Ports:
//   clk, rst, core_reset : clock, reset, core flush (both clear all state)
//   bus (slave)          : scheduler s_desc* and core in_desc* handshakes
//   slot_free_id/_valid  : slot release from the core's out_desc path
//   slots_in_use         : popcount of the slot-occupancy bitmap
//   fifo_count           : descriptors buffered (including the output stage)
//   err_dup_slot         : pulse, descriptor dropped, slot already owned
//   err_bad_slot         : pulse, descriptor dropped, slot ID out of range
//   err_free_idle        : pulse, release of a slot that is not owned
// Optional (macro CORE_IN_DESC_FEEDER_STATS_EN):
//   stat_desc_accepted, stat_desc_dropped : saturating counters
//   stat_max_fifo                         : fifo_count high-water mark
//   These are cleared by rst only, so they survive a core_reset.
module core_in_desc_feeder
    import core_desc_pkg::*;
#(
    parameter  int DEPTH      = 16,
    parameter  int SLOT_COUNT = 32,
    localparam int SLOT_W     = $clog2(SLOT_COUNT),
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 core_reset,
    core_in_desc_feeder_if.slave bus,
    input  logic [SLOT_ID_W-1:0] slot_free_id,
    input  logic                 slot_free_valid,
    output logic [SLOT_W:0]      slots_in_use,
    output logic [CW-1:0]        fifo_count,
    output logic                 err_dup_slot,
    output logic                 err_bad_slot,
    output logic                 err_free_idle
`ifdef CORE_IN_DESC_FEEDER_STATS_EN
    ,
    output logic [31:0]          stat_desc_accepted,
    output logic [31:0]          stat_desc_dropped,
    output logic [CW-1:0]        stat_max_fifo
`endif
);

    logic                  flush;
    logic                  accept;
    logic [SLOT_ID_W-1:0]  alloc_id;
    logic [SLOT_W-1:0]     alloc_idx, free_idx;
    logic                  alloc_in_range, free_in_range;
    logic                  free_hit, bad, dup, push;
    logic [SLOT_COUNT-1:0] bitmap, bitmap_freed, bitmap_next;
    logic [SLOT_W:0]       pop_next;

    assign flush    = rst || core_reset;
    assign accept   = bus.s_desc_valid && bus.s_desc_ready;
    assign alloc_id = bus.s_desc.slot;

    assign alloc_in_range = ({1'b0, alloc_id}     < 9'(SLOT_COUNT));
    assign free_in_range  = ({1'b0, slot_free_id} < 9'(SLOT_COUNT));
    assign alloc_idx      = alloc_id[SLOT_W-1:0];
    assign free_idx       = slot_free_id[SLOT_W-1:0];

    // Release is applied before the allocation check, so a slot freed and
    // re-allocated in the same cycle ends up owned with no error.
    always_comb begin
        bitmap_freed = bitmap;
        free_hit     = 1'b0;
        if (slot_free_valid && free_in_range) begin
            if (bitmap[free_idx]) begin
                free_hit               = 1'b1;
                bitmap_freed[free_idx] = 1'b0;
            end
        end
    end

    always_comb begin
        bad         = accept && !alloc_in_range;
        dup         = 1'b0;
        push        = 1'b0;
        bitmap_next = bitmap_freed;
        if (accept && alloc_in_range) begin
            if (bitmap_freed[alloc_idx]) begin
                dup = 1'b1;
            end else begin
                push                   = 1'b1;
                bitmap_next[alloc_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        pop_next = '0;
        for (int i = 0; i < SLOT_COUNT; i++) begin
            pop_next = pop_next + {{SLOT_W{1'b0}}, bitmap_next[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            bitmap        <= '0;
            slots_in_use  <= '0;
            err_bad_slot  <= 1'b0;
            err_dup_slot  <= 1'b0;
            err_free_idle <= 1'b0;
        end else begin
            bitmap        <= bitmap_next;
            slots_in_use  <= pop_next;
            err_bad_slot  <= bad;
            err_dup_slot  <= dup;
            err_free_idle <= slot_free_valid && !free_hit;
        end
    end

    core_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .flush (flush),
        .push  (push),
        .din   (bus.s_desc),
        .taken (bus.in_desc_taken),
        .dout  (bus.in_desc),
        .valid (bus.in_desc_valid),
        .ready (bus.s_desc_ready),
        .count (fifo_count)
    );

`ifdef CORE_IN_DESC_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_desc_accepted <= '0;
            stat_desc_dropped  <= '0;
            stat_max_fifo      <= '0;
        end else begin
            if (push && (stat_desc_accepted != '1)) begin
                stat_desc_accepted <= stat_desc_accepted + 32'd1;
            end
            if ((bad || dup) && (stat_desc_dropped != '1)) begin
                stat_desc_dropped <= stat_desc_dropped + 32'd1;
            end
            if (fifo_count > stat_max_fifo) begin
                stat_max_fifo <= fifo_count;
            end
        end
    end
`endif

endmodule
